// File: rtl/modulation_demod.sv
// Square-wave demodulator: drops a settling window after each half-period edge, sums the rest,
// and emits the saturated high-minus-low error once per full modulation period.
module modulation_demod #(
  parameter int unsigned ADC_BIT = 14,
  parameter int unsigned ACC_BIT = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic signed [ADC_BIT-1:0] i_adc_data,
  input  logic                      i_status,
  input  logic [15:0]               i_ignore,
  input  logic                      i_polarity,
  output logic signed [ACC_BIT-1:0] o_err,
  output logic                      o_err_vld,
  output logic                      o_sat,
  output logic                      o_locked
);

  localparam int unsigned ExtBit = ACC_BIT + 1;
  localparam logic signed [ACC_BIT-1:0] AccMax = {1'b0, {(ACC_BIT - 1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] AccMin = {1'b1, {(ACC_BIT - 1){1'b0}}};

  typedef enum logic [2:0] {
    StWaitSync,
    StSkipH,
    StAccH,
    StSkipL,
    StAccL
  } state_e;

  // Values held in ACC_BIT + 1 bits overflow ACC_BIT when the top two bits disagree.
  function automatic logic is_ovf(input logic signed [ExtBit-1:0] v);
    return v[ExtBit-1] ^ v[ExtBit-2];
  endfunction

  function automatic logic signed [ACC_BIT-1:0] clip(input logic signed [ExtBit-1:0] v);
    if (is_ovf(v)) begin
      return v[ExtBit-1] ? AccMin : AccMax;
    end
    return v[ACC_BIT-1:0];
  endfunction

  state_e                      state_q, state_d;
  logic                        status_q;
  logic [15:0]                 skip_cnt_q, skip_cnt_d;
  logic signed [ACC_BIT-1:0]   acc_h_q, acc_h_d;
  logic signed [ACC_BIT-1:0]   acc_l_q, acc_l_d;
  logic                        sat_flag_q, sat_flag_d;
  logic signed [ACC_BIT-1:0]   err_q, err_d;
  logic                        err_vld_q, err_vld_d;
  logic                        sat_q, sat_d;
  logic                        locked_q, locked_d;

  logic                        rise, fall;
  logic                        ignore_zero;
  logic signed [ExtBit-1:0]    sample_ext;
  logic signed [ExtBit-1:0]    sum_h, sum_l, diff;
  logic signed [ACC_BIT-1:0]   acc_start;
  logic [15:0]                 skip_start;
  logic                        skip_first;

  assign rise        = i_status & ~status_q;
  assign fall        = ~i_status & status_q;
  assign ignore_zero = (i_ignore == 16'd0);
  assign sample_ext  = {{(ExtBit - ADC_BIT){i_adc_data[ADC_BIT-1]}}, i_adc_data};
  assign sum_h       = {acc_h_q[ACC_BIT-1], acc_h_q} + sample_ext;
  assign sum_l       = {acc_l_q[ACC_BIT-1], acc_l_q} + sample_ext;
  assign diff        = i_polarity ? ({acc_l_q[ACC_BIT-1], acc_l_q} - {acc_h_q[ACC_BIT-1], acc_h_q})
                                  : ({acc_h_q[ACC_BIT-1], acc_h_q} - {acc_l_q[ACC_BIT-1], acc_l_q});

  // The edge-cycle sample is the first of the new half: it seeds the accumulator when nothing is
  // ignored, otherwise it is the first dropped sample, so skip_cnt tracks the drops still to come.
  assign acc_start   = ignore_zero ? sample_ext[ACC_BIT-1:0] : '0;
  assign skip_start  = ignore_zero ? 16'd0 : (i_ignore - 16'd1);
  assign skip_first  = (i_ignore > 16'd1);

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    acc_h_d    = acc_h_q;
    acc_l_d    = acc_l_q;
    sat_flag_d = sat_flag_q;
    err_d      = err_q;
    err_vld_d  = 1'b0;
    sat_d      = sat_q;
    locked_d   = locked_q;

    case (state_q)
      StWaitSync: begin
        if (rise) begin
          state_d    = skip_first ? StSkipH : StAccH;
          skip_cnt_d = skip_start;
          acc_h_d    = acc_start;
          sat_flag_d = 1'b0;
        end
      end
      StSkipH, StAccH: begin
        if (fall) begin
          state_d    = skip_first ? StSkipL : StAccL;
          skip_cnt_d = skip_start;
          acc_l_d    = acc_start;
        end else if (state_q == StSkipH) begin
          skip_cnt_d = skip_cnt_q - 16'd1;
          if (skip_cnt_q <= 16'd1) state_d = StAccH;
        end else begin
          acc_h_d = clip(sum_h);
          if (is_ovf(sum_h)) sat_flag_d = 1'b1;
        end
      end
      StSkipL, StAccL: begin
        if (rise) begin
          err_d      = clip(diff);
          sat_d      = sat_flag_q | is_ovf(diff);
          err_vld_d  = 1'b1;
          locked_d   = 1'b1;
          sat_flag_d = 1'b0;
          state_d    = skip_first ? StSkipH : StAccH;
          skip_cnt_d = skip_start;
          acc_h_d    = acc_start;
        end else if (state_q == StSkipL) begin
          skip_cnt_d = skip_cnt_q - 16'd1;
          if (skip_cnt_q <= 16'd1) state_d = StAccL;
        end else begin
          acc_l_d = clip(sum_l);
          if (is_ovf(sum_l)) sat_flag_d = 1'b1;
        end
      end
      default: state_d = StWaitSync;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StWaitSync;
      status_q   <= 1'b0;
      skip_cnt_q <= '0;
      acc_h_q    <= '0;
      acc_l_q    <= '0;
      sat_flag_q <= 1'b0;
      err_q      <= '0;
      err_vld_q  <= 1'b0;
      sat_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= i_status;
      skip_cnt_q <= skip_cnt_d;
      acc_h_q    <= acc_h_d;
      acc_l_q    <= acc_l_d;
      sat_flag_q <= sat_flag_d;
      err_q      <= err_d;
      err_vld_q  <= err_vld_d;
      sat_q      <= sat_d;
      locked_q   <= locked_d;
    end
  end

  assign o_err     = err_q;
  assign o_err_vld = err_vld_q;
  assign o_sat     = sat_q;
  assign o_locked  = locked_q;

endmodule
